// File: rtl/rf_pkg.sv
// Shared types and helpers for the pipelined register file slice.
// Pure declarations; no state, no timing.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // Address width for a given register count, never narrower than one bit.
  function automatic int rf_aw(input int depth);
    int aw;
    aw = $clog2(depth);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/pipe_reg_file_if.sv
// Decode/writeback bus of the register file: read ports, writeback, issue marking.
// Master is the pipeline, slave is the register file; ready gates every request.
interface pipe_reg_file_if
  import rf_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);

  localparam int AW = rf_aw(DEPTH);

  logic [NREAD*AW-1:0] rs;
  logic [NREAD*N-1:0]  rdata;
  logic [NREAD-1:0]    rs_busy;
  logic                mem_write;
  logic [AW-1:0]       rd;
  logic [N-1:0]        write_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                ready;

  modport master (
    output rs, mem_write, rd, write_data, issue_en, issue_rd,
    input  rdata, rs_busy, ready
  );

  modport slave (
    input  rs, mem_write, rd, write_data, issue_en, issue_rd,
    output rdata, rs_busy, ready
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending flags: set on issue, cleared on writeback, issue wins a tie.
// rs_busy is combinational; updates land on the next edge; gated off while not enabled.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mem_write,
  input  logic [AW-1:0]       rd,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  input  logic [NREAD*AW-1:0] rs,
  output logic [NREAD-1:0]    rs_busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    busy_nxt = busy;
    if (en && mem_write && in_range(rd)) begin
      busy_nxt[rd] = 1'b0;
    end
    // Applied after the clear: a newer producer outlives the older writeback.
    if (en && issue_en && in_range(issue_rd) && !is_zero_reg(issue_rd)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rs_busy[k] = en
                && in_range(rs[k*AW +: AW])
                && busy[rs[k*AW +: AW]]
                && !(mem_write && (rd == rs[k*AW +: AW]));
    end
  end

endmodule

// File: rtl/pipe_reg_file.sv
// Register file with zeroing sweep after reset, write-to-read bypass and pending scoreboard.
// Reads are zero-latency, writes visible next cycle; requests are dropped while ready is low.
module pipe_reg_file
  import rf_pkg::*;
#(
  parameter int N              = 32,
  parameter int DEPTH          = 32,
  parameter int NREAD          = 2,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  pipe_reg_file_if.slave bus
);

  localparam int            AW       = rf_aw(DEPTH);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t     state;
  rf_state_t     state_nxt;
  logic [AW-1:0] sweep_idx;
  logic [AW-1:0] sweep_idx_nxt;
  logic          ready;
  logic          sweep_we;
  logic          wr_act;
  logic          wr_commit;

  logic [N-1:0]  mem       [DEPTH];
  logic [N-1:0]  port_data [NREAD];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_nxt = RUN;
        end else if (sweep_idx == LAST_IDX) begin
          state_nxt = RUN;
        end else begin
          sweep_idx_nxt = sweep_idx + AW'(1);
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_comb begin
    ready    = (state == RUN);
    sweep_we = (state == CLEAR) && (CLEAR_ON_RESET != 0);
  end

  assign wr_act    = ready && bus.mem_write;
  assign wr_commit = wr_act && in_range(bus.rd) && !is_zero_reg(bus.rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem[sweep_idx] <= '0;
      end else if (wr_commit) begin
        mem[bus.rd] <= bus.write_data;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0] addr;
    assign addr = bus.rs[k*AW +: AW];
    // A writeback to the same register this cycle forwards its data ahead of the array.
    assign port_data[k] = (!ready || !in_range(addr) || is_zero_reg(addr)) ? '0 :
                          (wr_act && (bus.rd == addr))                      ? bus.write_data :
                                                                              mem[addr];
  end

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rdata[k*N +: N] = port_data[k];
    end
  end

  assign bus.ready = ready;

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .en        (ready),
    .mem_write (bus.mem_write),
    .rd        (bus.rd),
    .issue_en  (bus.issue_en),
    .issue_rd  (bus.issue_rd),
    .rs        (bus.rs),
    .rs_busy   (bus.rs_busy)
  );

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench: default 32x32/2-port file with sweep, plus a 24-entry 3-port file without sweep.
module tb_pipe_reg_file;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  pipe_reg_file_if #(.N(32), .DEPTH(32), .NREAD(2)) bus_a ();
  pipe_reg_file_if #(.N(32), .DEPTH(24), .NREAD(3)) bus_b ();

  pipe_reg_file #(
    .N(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  pipe_reg_file #(
    .N(32), .DEPTH(24), .NREAD(3), .ZERO_REG(1), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.mem_write  = 1'b0;
    bus_a.rd         = '0;
    bus_a.write_data = '0;
    bus_a.issue_en   = 1'b0;
    bus_a.issue_rd   = '0;
  endtask

  task automatic idle_b();
    bus_b.mem_write  = 1'b0;
    bus_b.rd         = '0;
    bus_b.write_data = '0;
    bus_b.issue_en   = 1'b0;
    bus_b.issue_rd   = '0;
  endtask

  task automatic set_rs_a(input logic [4:0] r0, input logic [4:0] r1);
    bus_a.rs = {r1, r0};
  endtask

  task automatic set_rs_b(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    bus_b.rs = {r2, r1, r0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_a();
    idle_b();
    set_rs_a(5'd0, 5'd0);
    set_rs_b(5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("a_reset_ready", 64'(bus_a.ready), 64'd0);
    check("a_reset_rdata", 64'(bus_a.rdata), 64'd0);
    check("a_reset_busy", 64'(bus_a.rs_busy), 64'd0);
    check("b_reset_ready", 64'(bus_b.ready), 64'd0);

    // Sweep length; write/issue held high during the sweep must be ignored
    rst_a = 1'b0;
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd3;
    bus_a.write_data = 32'h0000FFFF;
    bus_a.issue_en   = 1'b1;
    bus_a.issue_rd   = 5'd3;
    set_rs_a(5'd3, 5'd3);
    cnt = 0;
    while (!bus_a.ready && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 5) begin
        check("a_sweep_rdata_gated", 64'(bus_a.rdata), 64'd0);
        check("a_sweep_busy_gated", 64'(bus_a.rs_busy), 64'd0);
      end
    end
    idle_a();
    check("a_sweep_len", 64'(cnt), 64'd32);

    for (int r = 0; r < 32; r++) begin
      set_rs_a(5'(r), 5'(31 - r));
      #1;
      check("a_swept_zero", 64'(bus_a.rdata), 64'd0);
      check("a_swept_not_busy", 64'(bus_a.rs_busy), 64'd0);
      tick();
    end

    // Write with same-cycle bypass
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd5;
    bus_a.write_data = 32'hDEADBEEF;
    set_rs_a(5'd5, 5'd6);
    #1;
    check("bypass_port0", 64'(bus_a.rdata[31:0]), 64'hDEADBEEF);
    check("bypass_port1_other", 64'(bus_a.rdata[63:32]), 64'd0);
    tick();
    bus_a.mem_write = 1'b0;
    #1;
    check("write_stored", 64'(bus_a.rdata[31:0]), 64'hDEADBEEF);

    // Register zero ignores writes and issues
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd0;
    bus_a.write_data = 32'h00001234;
    bus_a.issue_en   = 1'b1;
    bus_a.issue_rd   = 5'd0;
    set_rs_a(5'd0, 5'd5);
    #1;
    check("zero_no_bypass", 64'(bus_a.rdata[31:0]), 64'd0);
    check("zero_busy_same", 64'(bus_a.rs_busy[0]), 64'd0);
    tick();
    idle_a();
    #1;
    check("zero_stored", 64'(bus_a.rdata[31:0]), 64'd0);
    check("zero_busy_after", 64'(bus_a.rs_busy), 64'd0);
    check("reg5_intact", 64'(bus_a.rdata[63:32]), 64'hDEADBEEF);

    // Scoreboard set, clear, and set-wins tie
    bus_a.issue_en = 1'b1;
    bus_a.issue_rd = 5'd7;
    set_rs_a(5'd0, 5'd7);
    #1;
    check("issue_not_yet_busy", 64'(bus_a.rs_busy[1]), 64'd0);
    tick();
    bus_a.issue_en = 1'b0;
    #1;
    check("issue_busy", 64'(bus_a.rs_busy), 64'd2);
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd7;
    bus_a.write_data = 32'h00000077;
    #1;
    check("wb_clears_hazard", 64'(bus_a.rs_busy[1]), 64'd0);
    check("wb_bypass7", 64'(bus_a.rdata[63:32]), 64'h77);
    tick();
    bus_a.mem_write = 1'b0;
    #1;
    check("wb_cleared", 64'(bus_a.rs_busy[1]), 64'd0);
    check("wb_stored7", 64'(bus_a.rdata[63:32]), 64'h77);
    bus_a.issue_en = 1'b1;
    bus_a.issue_rd = 5'd7;
    tick();
    bus_a.issue_en = 1'b0;
    #1;
    check("reissue_busy", 64'(bus_a.rs_busy[1]), 64'd1);
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd7;
    bus_a.write_data = 32'h00000088;
    bus_a.issue_en   = 1'b1;
    bus_a.issue_rd   = 5'd7;
    #1;
    check("tie_hazard_satisfied", 64'(bus_a.rs_busy[1]), 64'd0);
    tick();
    idle_a();
    #1;
    check("tie_set_wins", 64'(bus_a.rs_busy), 64'd2);
    check("tie_data7", 64'(bus_a.rdata[63:32]), 64'h88);

    // Reset mid-run, then again mid-sweep
    bus_a.mem_write  = 1'b1;
    bus_a.rd         = 5'd12;
    bus_a.write_data = 32'h0000CAFE;
    tick();
    idle_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("rst_run_ready_drop", 64'(bus_a.ready), 64'd0);
    repeat (10) tick();
    check("mid_sweep_not_ready", 64'(bus_a.ready), 64'd0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    cnt = 0;
    while (!bus_a.ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check("a_resweep_len", 64'(cnt), 64'd32);
    set_rs_a(5'd12, 5'd7);
    #1;
    check("resweep_zeroed", 64'(bus_a.rdata[31:0]), 64'd0);
    check("busy_cleared_by_rst", 64'(bus_a.rs_busy), 64'd0);

    // Second configuration: no sweep, 3 ports, out-of-range addresses
    rst_b = 1'b0;
    #1;
    check("b_ready_before_edge", 64'(bus_b.ready), 64'd0);
    tick();
    check("b_ready_one_cycle", 64'(bus_b.ready), 64'd1);
    bus_b.mem_write  = 1'b1;
    bus_b.rd         = 5'd4;
    bus_b.write_data = 32'hA5A5A5A5;
    tick();
    bus_b.rd         = 5'd23;
    bus_b.write_data = 32'h5A5A0023;
    tick();
    bus_b.rd         = 5'd30;
    bus_b.write_data = 32'h00000BAD;
    bus_b.issue_en   = 1'b1;
    bus_b.issue_rd   = 5'd30;
    set_rs_b(5'd4, 5'd23, 5'd30);
    #1;
    check("b_oor_no_bypass", 64'(bus_b.rdata[95:64]), 64'd0);
    tick();
    idle_b();
    #1;
    check("b_oor_read", 64'(bus_b.rdata[95:64]), 64'd0);
    check("b_oor_busy", 64'(bus_b.rs_busy), 64'd0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("b_rst_ready", 64'(bus_b.ready), 64'd0);
    tick();
    check("b_rerelease_ready", 64'(bus_b.ready), 64'd1);
    check("b_retained_4", 64'(bus_b.rdata[31:0]), 64'hA5A5A5A5);
    check("b_retained_23", 64'(bus_b.rdata[63:32]), 64'h5A5A0023);
    check("b_oor_after_rst", 64'(bus_b.rdata[95:64]), 64'd0);
    bus_b.issue_en = 1'b1;
    bus_b.issue_rd = 5'd23;
    tick();
    idle_b();
    #1;
    check("b_port1_busy", 64'(bus_b.rs_busy), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_file.md
# pipe_reg_file

Parametrised register file for the pipelined processor. It replaces the fixed 2-read, level-written array with clocked writeback, a multi-cycle zeroing sweep after reset, same-cycle write-to-read bypass, and a per-register pending scoreboard. The block sits between decode (read ports, issue marking) and writeback (write port), and gives hazard logic a busy flag for each source operand.

## Interface
- `N`, default 32: data width in bits.
- `DEPTH`, default 32: number of registers; must be at least 2. `AW` = `$clog2(DEPTH)`.
- `NREAD`, default 2: number of read ports.
- `ZERO_REG`, default 1: when 1, register 0 is hardwired to zero and never marked busy.
- `CLEAR_ON_RESET`, default 1: when 1, reset runs a zeroing sweep; when 0, contents are retained across reset.

Ports:
- `clk`, in, 1 bit: the single clock; all state updates on its rising edge.
- `rst`, in, 1 bit: reset, synchronous and active-high.
- `rs`, in, `NREAD*AW` bits: packed read addresses; port k uses bits `[k*AW +: AW]`.
- `rdata`, out, `NREAD*N` bits: packed read data, combinational.
- `rs_busy`, out, `NREAD` bits: pending flag for each read port, combinational.
- `mem_write`, in, 1 bit: writeback enable.
- `rd`, in, `AW` bits: writeback address.
- `write_data`, in, `N` bits: writeback data.
- `issue_en`, in, 1 bit: marks `issue_rd` as pending.
- `issue_rd`, in, `AW` bits: destination register of the instruction being issued.
- `ready`, out, 1 bit: high when the block accepts reads, writes and issues.

## Operation
- FSM states: `CLEAR`, `RUN`.
  - `rst` forces `CLEAR` with sweep index 0.
  - In `CLEAR` with `CLEAR_ON_RESET`=1, one register is zeroed per cycle at the index, and the index increments.
  - The FSM leaves `CLEAR` for `RUN` after index `DEPTH-1` is written.
  - With `CLEAR_ON_RESET`=0, `CLEAR` lasts exactly one cycle.
- Reset values:
  - `ready`=0.
  - All busy bits 0.
  - `rdata`=0 and `rs_busy`=0 while not `ready`.
  - Array contents after the sweep are 0 when `CLEAR_ON_RESET`=1.
- While not `ready`:
  - `mem_write` and `issue_en` are ignored.
  - The environment must hold them low; the bench checks that they have no effect.
- Write in `RUN`: when `mem_write`=1, register `rd` takes `write_data` at the clock edge. The write is suppressed when `rd`=0 and `ZERO_REG`=1.
- Read, for each port k:
  - If `ZERO_REG`=1 and the address is 0, `rdata` is 0.
  - Otherwise, if `mem_write`=1 in `RUN` and `rd` equals the read address, `rdata` is `write_data` (bypass).
  - Otherwise `rdata` is the stored value.
- Scoreboard:
  - `issue_en` sets `busy[issue_rd]`.
  - `mem_write` clears `busy[rd]`.
  - When both target the same register in the same cycle, the set wins and the bit stays 1, because a newer producer is in flight.
  - Issue to register 0 is ignored when `ZERO_REG`=1.
- `rs_busy[k]` = `busy[addr_k]` AND NOT (`mem_write` AND `rd`==`addr_k`). A writeback in progress satisfies the hazard in the same cycle.
- Out-of-range addresses (≥ `DEPTH`, when `DEPTH` is not a power of two):
  - Writes and issues to them are ignored.
  - Reads from them return 0 with busy=0.
- `rst` asserted mid-sweep or mid-`RUN`:
  - The sweep restarts at index 0.
  - All busy bits clear.
  - `ready` drops in the next cycle.

## Timing
- Reads and `rs_busy` are combinational from `rs`, `rd`, `mem_write` and `write_data`: zero latency.
- Writes and scoreboard updates are visible to reads one cycle later. Bypass covers the same cycle.
- With `CLEAR_ON_RESET`=1:
  - `ready` rises on the `DEPTH`-th rising edge after the edge that samples `rst` low, i.e. `DEPTH` cycles of `ready`=0 after reset release.
  - The first accepted write or issue occurs in the cycle `ready` is high.
- With `CLEAR_ON_RESET`=0, `ready` is high one cycle after reset release.

## Structure
- Shared package `rf_pkg`:
  - state enum `rf_state_t` (`CLEAR`, `RUN`);
  - helper function `rf_aw(depth)` returning `$clog2(depth)`, minimum 1.
- Sub-module `reg_scoreboard` (parameters `DEPTH`, `NREAD`, `ZERO_REG`): holds the busy vector, set/clear priority and `rs_busy` generation.
- The top level holds the array, the sweep FSM and counter, and the read muxes with bypass, generated per read port.

## Test plan
1. Reset sweep: pulse `rst` 1 cycle with `DEPTH`=32 → `ready`=0 for exactly 32 cycles, then 1; every register reads 0.
2. Write and bypass: `mem_write`=1, `rd`=5, `write_data`=0xDEADBEEF, `rs`[0]=5 in the same cycle → `rdata`[0]=0xDEADBEEF at once; the next cycle, with `mem_write`=0, it still reads 0xDEADBEEF.
3. Zero register: write 0x1234 to `rd`=0, issue `issue_rd`=0 → `rdata` at address 0 stays 0 and `rs_busy` stays 0.
4. Scoreboard: issue `issue_rd`=7, then `rs`[1]=7 → `rs_busy`[1]=1. Writeback `rd`=7 → `rs_busy`[1]=0 in that cycle. The same cycle with `issue_en`, `issue_rd`=7 also set → busy is 1 the next cycle.
5. Reset mid-sweep: assert `rst` at sweep index 10, release → `ready` stays low a full 32 more cycles; a busy bit set before the reset is cleared.
6. Parameter sweep: `NREAD`=3, `DEPTH`=24, `CLEAR_ON_RESET`=0 → `ready` 1 cycle after release; preloaded contents retained; a read of address 30 returns 0.
